// File: rtl/bank_read_arbiter.sv
// Per-bank round-robin read arbiter for single-port banks, with a fixed 3-cycle
// read pipeline back to the agents and bank-collision reporting.
module bank_read_arbiter #(
  parameter int NB_RDAGENT = 4,
  parameter int NB_BANK    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int BKW        = $clog2(NB_BANK)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NB_RDAGENT-1:0]          rden,
  input  logic [NB_RDAGENT*BKW-1:0]      rdbank,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
  output logic [NB_RDAGENT-1:0]          rdready,
  output logic [NB_RDAGENT-1:0]          rdvalid,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata,
  output logic [NB_BANK-1:0]             m_rden,
  output logic [NB_BANK*ADDR_WIDTH-1:0]  m_addr,
  input  logic [NB_BANK*DATA_WIDTH-1:0]  m_data,
  output logic                           collision,
  output logic [CNT_WIDTH-1:0]           collision_cnt
);
  localparam int IDW = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;

  logic [NB_BANK-1:0][IDW-1:0]        ptr_q;
  logic [NB_BANK-1:0][IDW-1:0]        ptr_nxt;
  logic [NB_BANK-1:0][IDW-1:0]        win_id;
  logic [NB_BANK-1:0][ADDR_WIDTH-1:0] win_addr;
  logic [NB_BANK-1:0]                 any_req;
  logic [NB_RDAGENT-1:0]              grant;
  logic                               multi_req;

  logic [NB_BANK-1:0]                 tag1_v;
  logic [NB_BANK-1:0]                 tag2_v;
  logic [NB_BANK-1:0][IDW-1:0]        tag1_id;
  logic [NB_BANK-1:0][IDW-1:0]        tag2_id;

  // Scan agents starting at the bank pointer; the first hit in that order wins.
  always_comb begin
    any_req   = '0;
    win_id    = '0;
    win_addr  = '0;
    ptr_nxt   = ptr_q;
    grant     = '0;
    multi_req = 1'b0;
    for (int b = 0; b < NB_BANK; b++) begin
      int nreq;
      nreq = 0;
      for (int k = 0; k < NB_RDAGENT; k++) begin
        int a;
        a = int'(ptr_q[b]) + k;
        if (a >= NB_RDAGENT) a = a - NB_RDAGENT;
        if (rden[a] && (rdbank[a*BKW +: BKW] == BKW'(b))) begin
          nreq = nreq + 1;
          if (!any_req[b]) begin
            any_req[b]  = 1'b1;
            win_id[b]   = IDW'(a);
            win_addr[b] = rdaddr[a*ADDR_WIDTH +: ADDR_WIDTH];
            grant[a]    = 1'b1;
            ptr_nxt[b]  = (a == NB_RDAGENT - 1) ? '0 : IDW'(a + 1);
          end
        end
      end
      if (nreq >= 2) multi_req = 1'b1;
    end
  end

  // Nothing is consumed while reset is held.
  assign rdready = grant & {NB_RDAGENT{aresetn}};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q         <= '0;
      m_rden        <= '0;
      m_addr        <= '0;
      tag1_v        <= '0;
      tag1_id       <= '0;
      tag2_v        <= '0;
      tag2_id       <= '0;
      rdvalid       <= '0;
      rddata        <= '0;
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else begin
      ptr_q   <= ptr_nxt;
      m_rden  <= any_req;
      tag1_v  <= any_req;
      tag1_id <= win_id;
      tag2_v  <= tag1_v;
      tag2_id <= tag1_id;
      for (int b = 0; b < NB_BANK; b++) begin
        if (any_req[b]) m_addr[b*ADDR_WIDTH +: ADDR_WIDTH] <= win_addr[b];
      end
      // tag2 lines up with the bank data, so route it straight to its owner.
      rdvalid <= '0;
      for (int b = 0; b < NB_BANK; b++) begin
        if (tag2_v[b]) begin
          rdvalid[tag2_id[b]]                        <= 1'b1;
          rddata[tag2_id[b]*DATA_WIDTH +: DATA_WIDTH] <= m_data[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      collision <= multi_req;
      if (multi_req && (collision_cnt != '1)) collision_cnt <= collision_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_bank_read_arbiter.sv
// Bench for bank_read_arbiter: table vectors, directed corner sequences and
// constrained-random traffic checked against a transaction-level model.
module tb_bank_read_arbiter;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [3:0]   rden = '0;
  logic [7:0]   rdbank = '0;
  logic [31:0]  rdaddr = '0;
  logic [3:0]   rdready;
  logic [3:0]   rdvalid;
  logic [127:0] rddata;
  logic [3:0]   m_rden;
  logic [31:0]  m_addr;
  logic [127:0] m_data = '0;
  logic         collision;
  logic [2:0]   collision_cnt;

  bank_read_arbiter #(.NB_RDAGENT(4), .NB_BANK(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .rden(rden), .rdbank(rdbank), .rdaddr(rdaddr),
    .rdready(rdready), .rdvalid(rdvalid), .rddata(rddata), .m_rden(m_rden), .m_addr(m_addr),
    .m_data(m_data), .collision(collision), .collision_cnt(collision_cnt)
  );

  always #5 aclk = ~aclk;

  // Bank memories: data appears one cycle after m_rden.
  logic [31:0] mem [4][256];
  always @(posedge aclk) begin
    for (int b = 0; b < 4; b++)
      if (m_rden[b]) m_data[b*32 +: 32] <= mem[b][m_addr[b*8 +: 8]];
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  typedef struct { int agent; logic [31:0] data; int due; } pend_t;
  pend_t       pend[$];
  int          ptr[4] = '{0, 0, 0, 0};
  int          cnt_m = 0;
  logic        coll_m = 1'b0;
  logic [31:0] last_data[4] = '{0, 0, 0, 0};
  logic [3:0]  last_rdy = '0;
  logic [3:0]  obs_rdy = '0;

  typedef struct { logic [3:0] en; logic [7:0] bk; logic [3:0] rdy; logic coll; logic [2:0] cnt; } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // One clock cycle: drive, check grants, clock, advance model, check outputs.
  task automatic step(input logic [3:0] en, input logic [7:0] bk, input logic [31:0] ad);
    int         win[4];
    logic [3:0] exp_rdy;
    logic [3:0] exp_vld;
    logic       coll_now;
    rden = en; rdbank = bk; rdaddr = ad;
    #3;
    exp_rdy = '0; coll_now = 1'b0;
    for (int b = 0; b < 4; b++) begin
      int best, bestd, n;
      best = -1; bestd = 99; n = 0;
      for (int a = 0; a < 4; a++) begin
        if (en[a] && int'(bk[2*a +: 2]) == b) begin
          int d;
          d = (a - ptr[b] + 4) % 4;  // distance from the pointer in round-robin order
          n++;
          if (d < bestd) begin bestd = d; best = a; end
        end
      end
      win[b] = best;
      if (n >= 2) coll_now = 1'b1;
      if (best >= 0 && aresetn) exp_rdy[best] = 1'b1;
    end
    obs_rdy = rdready;
    chk("rdready", rdready, exp_rdy);
    last_rdy = exp_rdy;
    @(posedge aclk);
    #1;
    cyc++;
    if (!aresetn) begin
      pend.delete();
      for (int i = 0; i < 4; i++) begin ptr[i] = 0; last_data[i] = '0; end
      cnt_m = 0; coll_m = 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (win[b] >= 0) begin
          pend.push_back('{win[b], mem[b][ad[win[b]*8 +: 8]], cyc + 2});
          ptr[b] = (win[b] + 1) % 4;
        end
      end
      coll_m = coll_now;
      if (coll_now && cnt_m < 7) cnt_m++;
    end
    exp_vld = '0;
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (pend[k].due == cyc) begin
        exp_vld[pend[k].agent] = 1'b1;
        last_data[pend[k].agent] = pend[k].data;
        pend.delete(k);
      end
    end
    chk("collision", collision, coll_m);
    chk("collision_cnt", collision_cnt, cnt_m);
    chk("rdvalid", rdvalid, exp_vld);
    for (int a = 0; a < 4; a++) chk("rddata", rddata[a*32 +: 32], last_data[a]);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step(4'h0, 8'h00, 32'h0);
    aresetn = 1'b1;
  endtask

  initial begin
    logic [3:0]  en;
    logic [7:0]  bk;
    logic [31:0] ad;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) mem[b][a] = $urandom;
    mem[2][8'h10] = 32'hCAFE0001;

    tbl[0] = '{4'b1010, 8'h00, 4'b0010, 1'b1, 3'd1};
    tbl[1] = '{4'b1010, 8'h00, 4'b1000, 1'b1, 3'd2};
    tbl[2] = '{4'b1010, 8'h00, 4'b0010, 1'b1, 3'd3};
    tbl[3] = '{4'b1000, 8'h00, 4'b1000, 1'b0, 3'd3};
    tbl[4] = '{4'b1111, 8'h55, 4'b0001, 1'b1, 3'd4};
    tbl[5] = '{4'b1111, 8'h55, 4'b0010, 1'b1, 3'd5};
    tbl[6] = '{4'b1111, 8'h55, 4'b0100, 1'b1, 3'd6};
    tbl[7] = '{4'b1111, 8'h55, 4'b1000, 1'b1, 3'd7};
    tbl[8] = '{4'b1111, 8'h55, 4'b0001, 1'b1, 3'd7};
    tbl[9] = '{4'b1111, 8'hE4, 4'b1111, 1'b0, 3'd7};

    // Reset held with a request pending: nothing may be granted.
    step(4'b0001, 8'h00, 32'h0);
    do_reset();

    // Single read from bank 2.
    step(4'b0001, 8'h02, 32'h10);
    chk("single_m_rden", m_rden, 4'b0100);
    chk("single_m_addr", m_addr[23:16], 8'h10);
    step(4'h0, 8'h00, 32'h0);
    step(4'h0, 8'h00, 32'h0);
    chk("single_rdvalid", rdvalid, 4'b0001);
    chk("single_rddata", rddata[31:0], 32'hCAFE0001);

    // Four agents on four distinct banks.
    step(4'hF, 8'hE4, 32'h44332211);
    chk("par_m_rden", m_rden, 4'hF);
    step(4'h0, 8'h00, 32'h0);
    step(4'h0, 8'h00, 32'h0);
    chk("par_rdvalid", rdvalid, 4'hF);

    // Reset right after acceptance drops the in-flight read.
    step(4'b0001, 8'h03, 32'h5);
    aresetn = 1'b0;
    step(4'h0, 8'h00, 32'h0);
    chk("rst_m_rden", m_rden, 4'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_rdvalid", rdvalid, 4'h0);
    chk("rst_rddata", rddata, 128'h0);
    aresetn = 1'b1;
    step(4'h0, 8'h00, 32'h0);
    step(4'h0, 8'h00, 32'h0);
    chk("rst_no_return", rdvalid, 4'h0);

    // Contention and fairness vectors from fresh pointers.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].bk, 32'h40302010);
      chk("tbl_ready", obs_rdy, tbl[i].rdy);
      chk("tbl_collision", collision, tbl[i].coll);
      chk("tbl_cnt", collision_cnt, tbl[i].cnt);
    end

    // Counter saturation over 10 colliding cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'hF, 8'hFF, 32'h0);
      chk("sat_cnt", collision_cnt, (i + 1 > 7) ? 7 : i + 1);
    end

    // Random traffic; agents hold a request until it is accepted.
    do_reset();
    en = '0; bk = '0; ad = '0;
    for (int n = 0; n < 400; n++) begin
      for (int a = 0; a < 4; a++) begin
        if (!en[a] || last_rdy[a]) begin
          en[a] = ($urandom_range(0, 3) != 0);
          bk[2*a +: 2] = 2'($urandom);
          ad[8*a +: 8] = 8'($urandom);
        end
      end
      aresetn = ($urandom_range(0, 63) != 0);
      step(en, bk, ad);
    end
    aresetn = 1'b1;
    step(4'h0, 8'h00, 32'h0);
    step(4'h0, 8'h00, 32'h0);
    step(4'h0, 8'h00, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
